// File: rtl/sram_readback_checker.sv
`default_nettype none
// ============================================================================
// Module   : sram_readback_checker
// Purpose  : Sweeps SRAM addresses 0..LAST_ADDR. For each address it reads a
//            serial word (MSB first) and compares it with SEED ^ address.
//            It counts mismatches and records the first failing address.
// Ports    : sysclk          - clock (rising edge)
//            RST             - synchronous active-high reset
//            START / SEED    - sweep start pulse and pattern seed
//            SRAMDOUT        - serial read data from the SRAM
//            SRAMA / SRAMCEN - read address / active-low chip enable
//            BUSY / DONE     - sweep in progress / end-of-sweep pulse
//            PASS / ERRCNT / FIRST_ERR_ADDR - sweep result
//            RDWORD / RDVALID - last deserialized word and its strobe
// Revision : 1.0 - initial release
// ============================================================================
module sram_readback_checker #(
    parameter int WORD_W    = 16,
    parameter int ADDR_W    = 14,
    parameter int LAST_ADDR = 16383,
    parameter int RD_LAT    = 2,
    parameter int ERR_W     = 16
) (
    input  logic              sysclk,
    input  logic              RST,
    input  logic              START,
    input  logic [WORD_W-1:0] SEED,
    input  logic              SRAMDOUT,
    output logic [ADDR_W-1:0] SRAMA,
    output logic              SRAMCEN,
    output logic              BUSY,
    output logic              DONE,
    output logic              PASS,
    output logic [ERR_W-1:0]  ERRCNT,
    output logic [ADDR_W-1:0] FIRST_ERR_ADDR,
    output logic [WORD_W-1:0] RDWORD,
    output logic              RDVALID
);

    localparam logic [2:0] c_st_idle   = 3'd0;
    localparam logic [2:0] c_st_setup  = 3'd1;
    localparam logic [2:0] c_st_wait   = 3'd2;
    localparam logic [2:0] c_st_shift  = 3'd3;
    localparam logic [2:0] c_st_check  = 3'd4;
    localparam logic [2:0] c_st_finish = 3'd5;

    // One down-counter serves both WAIT (RD_LAT <= 15) and SHIFT (WORD_W).
    localparam int c_cnt_w = ($clog2(WORD_W) > 4) ? $clog2(WORD_W) : 4;
    localparam logic [c_cnt_w-1:0] c_wait_load  = c_cnt_w'(RD_LAT - 1);
    localparam logic [c_cnt_w-1:0] c_shift_load = c_cnt_w'(WORD_W - 1);
    localparam logic [ADDR_W-1:0]  c_last_addr  = ADDR_W'(LAST_ADDR);

    logic [2:0]         r_state;
    logic [2:0]         w_next_state;
    logic [c_cnt_w-1:0] r_cnt;
    logic [WORD_W-1:0]  r_seed;
    logic [ADDR_W-1:0]  r_addr;
    logic [WORD_W-1:0]  r_shift;
    logic [WORD_W-1:0]  r_rdword;
    logic [ERR_W-1:0]   r_errcnt;
    logic [ADDR_W-1:0]  r_first;
    logic               r_pass;

    logic               w_cnt_zero;
    logic [WORD_W-1:0]  w_shift_in;
    logic [WORD_W-1:0]  w_expected;
    logic               w_mismatch;

    assign w_cnt_zero = (r_cnt == '0);
    assign w_shift_in = {r_shift[WORD_W-2:0], SRAMDOUT};
    // The address is zero-extended or truncated to the word width by the cast.
    assign w_expected = r_seed ^ WORD_W'(r_addr);
    assign w_mismatch = (r_rdword != w_expected);

    // State register
    always_ff @(posedge sysclk) begin
        if (RST) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state and state-decoded outputs
    always_comb begin
        w_next_state = r_state;
        BUSY         = 1'b0;
        SRAMCEN      = 1'b1;
        DONE         = 1'b0;
        RDVALID      = 1'b0;
        case (r_state)
            c_st_idle: begin
                if (START) begin
                    w_next_state = c_st_setup;
                end
            end
            c_st_setup: begin
                BUSY         = 1'b1;
                SRAMCEN      = 1'b0;
                w_next_state = c_st_wait;
            end
            c_st_wait: begin
                BUSY    = 1'b1;
                SRAMCEN = 1'b0;
                if (w_cnt_zero) begin
                    w_next_state = c_st_shift;
                end
            end
            c_st_shift: begin
                BUSY    = 1'b1;
                SRAMCEN = 1'b0;
                if (w_cnt_zero) begin
                    w_next_state = c_st_check;
                end
            end
            c_st_check: begin
                BUSY    = 1'b1;
                RDVALID = 1'b1;
                if (r_addr == c_last_addr) begin
                    w_next_state = c_st_finish;
                end else begin
                    w_next_state = c_st_setup;
                end
            end
            c_st_finish: begin
                DONE         = 1'b1;
                w_next_state = c_st_idle;
            end
            default: begin
                w_next_state = c_st_idle;
            end
        endcase
    end

    // Datapath
    always_ff @(posedge sysclk) begin
        if (RST) begin
            r_cnt    <= '0;
            r_seed   <= '0;
            r_addr   <= '0;
            r_shift  <= '0;
            r_rdword <= '0;
            r_errcnt <= '0;
            r_first  <= '1;
            r_pass   <= 1'b0;
        end else begin
            case (r_state)
                c_st_idle: begin
                    if (START) begin
                        r_seed   <= SEED;
                        r_addr   <= '0;
                        r_errcnt <= '0;
                        r_first  <= '1;
                        r_pass   <= 1'b0;
                    end
                end
                c_st_setup: begin
                    r_cnt <= c_wait_load;
                end
                c_st_wait: begin
                    if (w_cnt_zero) begin
                        r_cnt <= c_shift_load;
                    end else begin
                        r_cnt <= r_cnt - c_cnt_w'(1);
                    end
                end
                c_st_shift: begin
                    r_shift <= w_shift_in;
                    r_cnt   <= r_cnt - c_cnt_w'(1);
                    // Publish the completed word so it is on RDWORD during CHECK.
                    if (w_cnt_zero) begin
                        r_rdword <= w_shift_in;
                    end
                end
                c_st_check: begin
                    if (w_mismatch) begin
                        if (r_errcnt != '1) begin
                            r_errcnt <= r_errcnt + ERR_W'(1);
                        end
                        if (r_errcnt == '0) begin
                            r_first <= r_addr;
                        end
                    end
                    if (r_addr != c_last_addr) begin
                        r_addr <= r_addr + ADDR_W'(1);
                    end
                end
                c_st_finish: begin
                    r_pass <= (r_errcnt == '0);
                end
                default: begin
                end
            endcase
        end
    end

    assign SRAMA          = r_addr;
    assign PASS           = r_pass;
    assign ERRCNT         = r_errcnt;
    assign FIRST_ERR_ADDR = r_first;
    assign RDWORD         = r_rdword;

endmodule
`default_nettype wire

// File: doc/sram_readback_checker.md
SRAM_READBACK_CHECKER -- requirements
Module: sram_readback_checker

Interface
Parameters (name, default, meaning):
REQ-001 The block SHALL declare the following parameters:
- WORD_W, 16: SRAM word width, in bits.
- ADDR_W, 14: SRAM address width.
- LAST_ADDR, 16383: final address checked; the sweep runs 0..LAST_ADDR.
- RD_LAT, 2: cycles from address presentation to the first SRAMDOUT bit; legal range 1..15.
- ERR_W, 16: error counter width.

Ports (name, direction, width, meaning):
REQ-002 The block SHALL have the following ports:
- sysclk, in, 1: the single clock; all logic is rising-edge triggered.
- RST, in, 1: synchronous, active-high reset.
- START, in, 1: single-cycle pulse that begins a sweep.
- SEED, in, WORD_W: pattern seed, captured when a sweep is accepted.
- SRAMDOUT, in, 1: serial read data from the BNN SRAM, MSB first.
- SRAMA, out, ADDR_W: read address.
- SRAMCEN, out, 1: chip enable, active-low.
- BUSY, out, 1: a sweep is in progress.
- DONE, out, 1: one-cycle pulse at the end of a sweep.
- PASS, out, 1: result of the last completed sweep; 1 means zero errors.
- ERRCNT, out, ERR_W: mismatch count for the current or last sweep.
- FIRST_ERR_ADDR, out, ADDR_W: address of the first mismatch.
- RDWORD, out, WORD_W: last deserialized word.
- RDVALID, out, 1: one-cycle pulse when RDWORD updates.

Function
REQ-003 The block SHALL implement the states IDLE, SETUP, WAIT, SHIFT, CHECK and FINISH.
REQ-004 IDLE -> SETUP SHALL occur when START=1 and RST=0. On that transition the block SHALL:
- capture SEED;
- set the address to 0;
- clear ERRCNT;
- set FIRST_ERR_ADDR to all-ones;
- clear PASS.
REQ-005 START SHALL be ignored in every state other than IDLE.
REQ-006 SETUP SHALL last 1 cycle: drive SRAMA with the current address and SRAMCEN=0, then go to WAIT.
REQ-007 WAIT SHALL last RD_LAT cycles, counted by a down-counter, with SRAMCEN held at 0, then go to SHIFT.
REQ-008 SHIFT SHALL last exactly WORD_W cycles.
- Each cycle it SHALL shift SRAMDOUT into the LSB of a shift register, so the first sampled bit becomes the MSB.
- SRAMCEN SHALL be held at 0 throughout SHIFT.
REQ-009 CHECK SHALL last 1 cycle. During CHECK the block SHALL:
- drive SRAMCEN=1;
- load RDWORD from the shift register and pulse RDVALID;
- compare RDWORD against the expected value.
REQ-010 The expected value SHALL be the captured SEED XOR the current address, zero-extended or truncated to WORD_W.
REQ-011 On a mismatch, ERRCNT SHALL increment and saturate at 2^ERR_W-1, never wrapping.
REQ-012 On a mismatch, FIRST_ERR_ADDR SHALL load the current address only if ERRCNT was 0 before that CHECK.
REQ-013 From CHECK: if the address is LAST_ADDR, go to FINISH; otherwise increment the address and go to SETUP.
REQ-014 The address SHALL never increment past LAST_ADDR.
REQ-015 FINISH SHALL last 1 cycle: pulse DONE, set PASS=1 if ERRCNT=0, then return to IDLE.
REQ-016 BUSY SHALL be 1 in SETUP, WAIT, SHIFT and CHECK, and 0 in IDLE and FINISH.
REQ-017 SRAMCEN SHALL be 1 in IDLE, CHECK and FINISH.
REQ-018 SRAMA SHALL hold its value from SETUP through CHECK, and hold its last value in IDLE.
REQ-019 Per-word latency SHALL be 2+RD_LAT+WORD_W cycles, which is 20 with the defaults.
REQ-020 DONE SHALL assert (LAST_ADDR+1)*(2+RD_LAT+WORD_W)+1 cycles after the START cycle.
REQ-021 PASS, ERRCNT, FIRST_ERR_ADDR and RDWORD SHALL hold their values in IDLE until the next accepted START.
REQ-022 If START coincides with the FINISH cycle, it SHALL be ignored.

Reset
REQ-023 When RST=1 at a rising edge, from any state including mid-sweep, the block SHALL go to IDLE and reset its outputs:
- SRAMCEN=1;
- SRAMA, BUSY, DONE, PASS, RDVALID, ERRCNT and RDWORD = 0;
- FIRST_ERR_ADDR = all-ones.
REQ-024 RST SHALL take priority over START in the same cycle, and no DONE pulse SHALL be generated for an aborted sweep.

Verification
Bench settings: LAST_ADDR=3, RD_LAT=2, WORD_W=16.
REQ-025 Clean sweep: SEED=16'hA5A0, and the SRAM model returns SEED^addr. Required response:
- 4 RDVALID pulses with values A5A0, A5A1, A5A2, A5A3;
- DONE exactly 81 cycles after START;
- PASS=1, ERRCNT=0, FIRST_ERR_ADDR=14'h3FFF.
REQ-026 Single fault: the model flips bit 0 at address 2. Required response: ERRCNT=1, FIRST_ERR_ADDR=2, PASS=0.
REQ-027 Saturation: ERR_W=2 and every word is corrupted. Required response: ERRCNT reads 1, 2, 3, 3 after each CHECK, and FIRST_ERR_ADDR=0.
REQ-028 Reset mid-operation: RST is pulsed during SHIFT of address 1. Required response:
- the next cycle shows IDLE, BUSY=0, SRAMCEN=1, ERRCNT=0;
- no DONE pulse;
- a subsequent START runs a complete sweep from address 0.
REQ-029 Busy START and collisions: START pulses during WAIT and during FINISH SHALL have no effect. START coinciding with RST SHALL not begin a sweep.
REQ-030 Timing check: SRAMCEN=0 for exactly 1+RD_LAT+WORD_W=19 consecutive cycles per word. SRAMA SHALL be stable throughout those cycles.
